// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the serial sequence generator.
package seq_gen_pkg;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam int DEFAULT_MAX_LEN = 16;
  localparam int REPEAT_W        = 8;
  localparam int GAP_W           = 4;
endpackage

// File: rtl/seq_shift_reg.sv
// Parallel-load, MSB-out shift register; a load left-aligns the active
// length-bit window so the first bit to send always sits at the top.
module seq_shift_reg
  import seq_gen_pkg::*;
#(
  parameter int MAX_LEN = DEFAULT_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               shift,
  input  logic [MAX_LEN-1:0] pattern_in,
  input  logic [LEN_W-1:0]   length_in,
  output logic               msb
);
  logic [MAX_LEN-1:0] data_reg;
  logic [LEN_W:0]     align;

  // length_in is 1..MAX_LEN whenever load is asserted, so align never underflows
  assign align = (LEN_W + 1)'(MAX_LEN) - {1'b0, length_in};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_reg <= '0;
    end else if (load) begin
      data_reg <= pattern_in << align;
    end else if (shift) begin
      data_reg <= {data_reg[MAX_LEN-2:0], 1'b0};
    end
  end

  assign msb = data_reg[MAX_LEN-1];
endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: captures a pattern on start and sends it
// MSB-first, optionally repeating it with an idle gap between frames.
module sequence_generator
  import seq_gen_pkg::*;
#(
  parameter int MAX_LEN = DEFAULT_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [MAX_LEN-1:0]  pattern_in,
  input  logic [LEN_W-1:0]    length_in,
  input  logic [REPEAT_W-1:0] repeat_in,
  input  logic [GAP_W-1:0]    gap_in,
  output logic                sequence_out,
  output logic                bit_valid,
  output logic                frame_start,
  output logic                busy,
  output logic                done
);
  state_t state_reg, state_next;
  logic [MAX_LEN-1:0]  pat_reg, pat_next;
  logic [LEN_W-1:0]    len_reg, len_next, len_clamped;
  logic [GAP_W-1:0]    gap_reg, gap_next;
  logic [LEN_W-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [REPEAT_W-1:0] frame_cnt_reg, frame_cnt_next;
  logic [GAP_W-1:0]    gap_cnt_reg, gap_cnt_next;
  logic bit_valid_reg, bit_valid_next;
  logic frame_start_reg, frame_start_next;
  logic busy_reg, busy_next;
  logic done_reg, done_next;
  logic sr_load, sr_shift, sr_msb;
  logic [MAX_LEN-1:0] sr_pattern;
  logic [LEN_W-1:0]   sr_length;

  assign len_clamped = (length_in > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : length_in;

  seq_shift_reg #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_shift (
    .clock     (clock),
    .reset     (reset),
    .load      (sr_load),
    .shift     (sr_shift),
    .pattern_in(sr_pattern),
    .length_in (sr_length),
    .msb       (sr_msb)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      pat_reg         <= '0;
      len_reg         <= '0;
      gap_reg         <= '0;
      bit_cnt_reg     <= '0;
      frame_cnt_reg   <= '0;
      gap_cnt_reg     <= '0;
      bit_valid_reg   <= 1'b0;
      frame_start_reg <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pat_reg         <= pat_next;
      len_reg         <= len_next;
      gap_reg         <= gap_next;
      bit_cnt_reg     <= bit_cnt_next;
      frame_cnt_reg   <= frame_cnt_next;
      gap_cnt_reg     <= gap_cnt_next;
      bit_valid_reg   <= bit_valid_next;
      frame_start_reg <= frame_start_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pat_next         = pat_reg;
    len_next         = len_reg;
    gap_next         = gap_reg;
    bit_cnt_next     = bit_cnt_reg;
    frame_cnt_next   = frame_cnt_reg;
    gap_cnt_next     = gap_cnt_reg;
    bit_valid_next   = 1'b0;
    frame_start_next = 1'b0;
    busy_next        = 1'b0;
    done_next        = 1'b0;
    sr_load          = 1'b0;
    sr_shift         = 1'b0;
    // the shift register loads straight from the inputs on the accepting edge
    sr_pattern       = (state_reg == IDLE) ? pattern_in : pat_reg;
    sr_length        = (state_reg == IDLE) ? len_clamped : len_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (len_clamped == '0) begin
            done_next = 1'b1;
          end else begin
            pat_next         = pattern_in;
            len_next         = len_clamped;
            gap_next         = gap_in;
            frame_cnt_next   = repeat_in;
            bit_cnt_next     = len_clamped - LEN_W'(1);
            sr_load          = 1'b1;
            bit_valid_next   = 1'b1;
            frame_start_next = 1'b1;
            busy_next        = 1'b1;
            state_next       = SEND;
          end
        end
      end
      SEND: begin
        if (abort) begin
          state_next = IDLE;
        end else if (bit_cnt_reg != '0) begin
          sr_shift       = 1'b1;
          bit_cnt_next   = bit_cnt_reg - LEN_W'(1);
          bit_valid_next = 1'b1;
          busy_next      = 1'b1;
        end else if (frame_cnt_reg != '0) begin
          frame_cnt_next = frame_cnt_reg - REPEAT_W'(1);
          busy_next      = 1'b1;
          if (gap_reg != '0) begin
            gap_cnt_next = gap_reg - GAP_W'(1);
            state_next   = GAP;
          end else begin
            sr_load          = 1'b1;
            bit_cnt_next     = len_reg - LEN_W'(1);
            bit_valid_next   = 1'b1;
            frame_start_next = 1'b1;
          end
        end else begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      GAP: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          busy_next = 1'b1;
          if (gap_cnt_reg == '0) begin
            sr_load          = 1'b1;
            bit_cnt_next     = len_reg - LEN_W'(1);
            bit_valid_next   = 1'b1;
            frame_start_next = 1'b1;
            state_next       = SEND;
          end else begin
            gap_cnt_next = gap_cnt_reg - GAP_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign sequence_out = bit_valid_reg & sr_msb;
  assign bit_valid    = bit_valid_reg;
  assign frame_start  = frame_start_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
endmodule

// File: tb/tb_sequence_generator.sv
// Directed self-checking bench for sequence_generator.
module tb_sequence_generator;
  logic        clock;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] pattern_in;
  logic [4:0]  length_in;
  logic [7:0]  repeat_in;
  logic [3:0]  gap_in;
  logic        sequence_out;
  logic        bit_valid;
  logic        frame_start;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  sequence_generator dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .pattern_in  (pattern_in),
    .length_in   (length_in),
    .repeat_in   (repeat_in),
    .gap_in      (gap_in),
    .sequence_out(sequence_out),
    .bit_valid   (bit_valid),
    .frame_start (frame_start),
    .busy        (busy),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      obs = {sequence_out, bit_valid, frame_start, busy, done};
      checks++;
      if (obs !== 5'b0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got %b expected 00000", i, obs);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      obs = {sequence_out, bit_valid, frame_start, busy, done};
      checks++;
      if (obs !== 5'b0) begin
        errors++;
        $display("FAIL idle_outputs cycle %0d: got %b expected 00000", i, obs);
      end
    end
    $display("test_reset: idle after reset");
  endtask

  task automatic test_single();
    logic [3:0] exp_bits;
    logic [3:0] win;
    logic [3:0] obs;
    int hits;
    exp_bits = 4'b1011;
    win = 4'b0;
    hits = 0;
    pattern_in = 16'h000B; length_in = 5'd4; repeat_in = 8'd0; gap_in = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      obs = {sequence_out, bit_valid, frame_start, busy};
      checks++;
      if (obs !== {exp_bits[3-i], 1'b1, (i == 0), 1'b1}) begin
        errors++;
        $display("FAIL single_bit %0d: got %b expected %b", i, obs,
                 {exp_bits[3-i], 1'b1, (i == 0), 1'b1});
      end
      if (bit_valid) begin
        win = {win[2:0], sequence_out};
        if (win == 4'b1011) hits++;
      end
      tick();
    end
    checks++;
    if ({done, busy, bit_valid} !== 3'b100) begin
      errors++;
      $display("FAIL single_done: got done/busy/valid %b expected 100", {done, busy, bit_valid});
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL single_done_width: got done %b expected 0", done);
    end
    checks++;
    if (hits != 1) begin
      errors++;
      $display("FAIL single_detector: got %0d hits expected 1", hits);
    end
    $display("test_single: pattern 1011 sent, detector hits=%0d", hits);
  endtask

  task automatic test_repeat_gap();
    logic [3:0] obs, exp;
    int pos;
    int fs_count;
    fs_count = 0;
    pattern_in = 16'h0006; length_in = 5'd3; repeat_in = 8'd2; gap_in = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 13; k++) begin
      pos = k % 5;
      exp = {(pos < 2), (pos < 3), (pos == 0), 1'b1};
      obs = {sequence_out, bit_valid, frame_start, busy};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL repeat_cycle %0d: got %b expected %b", k, obs, exp);
      end
      if (frame_start) fs_count++;
      tick();
    end
    checks++;
    if ({done, busy} !== 2'b10) begin
      errors++;
      $display("FAIL repeat_done: got done/busy %b expected 10", {done, busy});
    end
    checks++;
    if (fs_count != 3) begin
      errors++;
      $display("FAIL repeat_frame_starts: got %0d expected 3", fs_count);
    end
    tick();
    $display("test_repeat_gap: 3 frames with gap 2, frame_starts=%0d", fs_count);
  endtask

  task automatic test_boundaries();
    logic [15:0] exp_pat;
    logic [2:0]  obs;
    pattern_in = 16'hFFFF; length_in = 5'd0; repeat_in = 8'd0; gap_in = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    obs = {done, busy, bit_valid};
    checks++;
    if (obs !== 3'b100) begin
      errors++;
      $display("FAIL len0_done: got done/busy/valid %b expected 100", obs);
    end
    tick();
    obs = {done, busy, bit_valid};
    checks++;
    if (obs !== 3'b000) begin
      errors++;
      $display("FAIL len0_after: got done/busy/valid %b expected 000", obs);
    end
    $display("test_boundaries: length 0 rejected");

    exp_pat = 16'hA5C3;
    pattern_in = 16'hA5C3; length_in = 5'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      obs = {sequence_out, bit_valid, busy};
      checks++;
      if (obs !== {exp_pat[15-i], 2'b11}) begin
        errors++;
        $display("FAIL clamp_bit %0d: got %b expected %b", i, obs, {exp_pat[15-i], 2'b11});
      end
      tick();
    end
    checks++;
    if ({done, busy} !== 2'b10) begin
      errors++;
      $display("FAIL clamp_done: got done/busy %b expected 10", {done, busy});
    end
    tick();
    $display("test_boundaries: length 20 clamped to 16 bits");
  endtask

  task automatic test_abort();
    logic [3:0] exp_bits;
    logic [3:0] obs;
    pattern_in = 16'h000D; length_in = 5'd4; repeat_in = 8'd0; gap_in = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if ({sequence_out, bit_valid} !== 2'b01) begin
      errors++;
      $display("FAIL abort_bit2: got seq/valid %b expected 01", {sequence_out, bit_valid});
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    obs = {sequence_out, bit_valid, busy, done};
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL abort_outputs: got %b expected 0000", obs);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: got done %b expected 0", done);
    end

    exp_bits = 4'b1001;
    pattern_in = 16'h0009;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      obs = {sequence_out, bit_valid, frame_start, busy};
      checks++;
      if (obs !== {exp_bits[3-i], 1'b1, (i == 0), 1'b1}) begin
        errors++;
        $display("FAIL after_abort_bit %0d: got %b expected %b", i, obs,
                 {exp_bits[3-i], 1'b1, (i == 0), 1'b1});
      end
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL after_abort_done: got done %b expected 1", done);
    end
    tick();
    $display("test_abort: aborted at bit 2, restart sent 1001");
  endtask

  task automatic test_reset_in_gap();
    logic [4:0] obs;
    pattern_in = 16'h0002; length_in = 5'd2; repeat_in = 8'd1; gap_in = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if ({sequence_out, bit_valid, busy} !== 3'b001) begin
      errors++;
      $display("FAIL gap_state: got seq/valid/busy %b expected 001", {sequence_out, bit_valid, busy});
    end
    #3;
    reset = 1'b1;
    #1;
    obs = {sequence_out, bit_valid, frame_start, busy, done};
    checks++;
    if (obs !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_gap: got %b expected 00000", obs);
    end
    #1;
    reset = 1'b0;
    tick();
    obs = {sequence_out, bit_valid, frame_start, busy, done};
    checks++;
    if (obs !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_gap_idle: got %b expected 00000", obs);
    end
    $display("test_reset_in_gap: asynchronous clear during gap");
  endtask

  task automatic test_back_to_back();
    logic [4:0] obs;
    logic [4:0] exp [6];
    // {seq, valid, frame_start, busy, done}
    exp[0] = 5'b11110;
    exp[1] = 5'b01010;
    exp[2] = 5'b00001;
    exp[3] = 5'b01110;
    exp[4] = 5'b11010;
    exp[5] = 5'b00001;
    pattern_in = 16'h0002; length_in = 5'd2; repeat_in = 8'd0; gap_in = 4'd0;
    start = 1'b1;
    tick();
    pattern_in = 16'h0001;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) start = 1'b0;
      obs = {sequence_out, bit_valid, frame_start, busy, done};
      checks++;
      if (obs !== exp[k]) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", k, obs, exp[k]);
      end
      tick();
    end
    $display("test_back_to_back: frames 10 then 01 with start held");
  endtask

  task automatic test_ignored_start();
    logic [3:0] exp_bits;
    logic [2:0] obs;
    exp_bits = 4'b1011;
    pattern_in = 16'h000B; length_in = 5'd4; repeat_in = 8'd0; gap_in = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        start = 1'b1;
        pattern_in = 16'h0004;
        length_in = 5'd3;
      end else begin
        start = 1'b0;
      end
      obs = {sequence_out, bit_valid, busy};
      checks++;
      if (obs !== {exp_bits[3-i], 2'b11}) begin
        errors++;
        $display("FAIL ignored_start_bit %0d: got %b expected %b", i, obs, {exp_bits[3-i], 2'b11});
      end
      tick();
    end
    checks++;
    if ({done, busy} !== 2'b10) begin
      errors++;
      $display("FAIL ignored_start_done: got done/busy %b expected 10", {done, busy});
    end
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL ignored_start_idle: got busy/done %b expected 00", {busy, done});
    end
    $display("test_ignored_start: mid-frame start had no effect");
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    pattern_in = '0;
    length_in = '0;
    repeat_in = '0;
    gap_in = '0;
    test_reset();
    test_single();
    test_repeat_gap();
    test_boundaries();
    test_abort();
    test_reset_in_gap();
    test_back_to_back();
    test_ignored_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sequence_generator.md
# sequence_generator

Serial pattern transmitter that drives a 1-bit stream for the team's sequence detectors, as the transmit end of the same serial bit line. It captures a pattern of 1..MAX_LEN bits on a start handshake and emits it MSB-first, one bit per clock. It optionally repeats the frame with an idle gap between copies. It replaces hand-timed `sequence_in` stimulus and sits upstream of any detector block, either in benches or in on-chip self-test.

## Interface
- MAX_LEN, 16: maximum pattern length in bits; legal range 2..32.
- LEN_W, $clog2(MAX_LEN+1): width of the length field.
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE and clears all outputs.
- start  in  1  request; sampled only when busy=0.
- abort  in  1  synchronous; terminates the current transfer.
- pattern_in  in  MAX_LEN  pattern; the active bits are [length-1:0], MSB sent first.
- length_in  in  LEN_W  number of bits per frame.
- repeat_in  in  8  additional frames; total frames = repeat_in+1.
- gap_in  in  4  idle cycles between frames.
- sequence_out  out  1  serial data; 0 whenever bit_valid=0.
- bit_valid  out  1  sequence_out carries a pattern bit.
- frame_start  out  1  high with the first bit of every frame.
- busy  out  1  high in SEND and GAP.
- done  out  1  one-cycle pulse after the final bit of the final frame.

## Operation
- Reset value of every output is 0. The state machine resets to IDLE.
- States and transitions:
  - IDLE -> SEND on start, when the clamped length is ≥1.
  - SEND -> SEND while bits remain in the current frame.
  - SEND -> GAP after the last bit, when frames remain and gap_in>0.
  - SEND -> SEND (next frame) after the last bit, when frames remain and gap_in=0.
  - SEND -> IDLE with done after the last bit of the final frame.
  - GAP -> SEND after the captured gap count expires.
  - SEND or GAP -> IDLE on abort, with no done pulse.
- Capture on accepted start: pattern, length, repeat and gap are all captured at that edge. Later changes to the inputs have no effect until the next start.
- length_in=0 is rejected: done pulses on the next cycle, no bits are sent, busy stays 0.
- length_in>MAX_LEN is clamped to MAX_LEN.
- Bit order:
  - Frame bit i (i=0..L-1) is pattern[L-1-i].
  - A shift register is reloaded from the captured pattern at the start of every frame.
- Counters:
  - The bit counter counts L-1 down to 0.
  - The frame counter counts captured repeat down to 0; it decrements on the last bit of each frame.
  - The gap counter counts gap_in-1 down to 0.
  - No counter wraps. All three are reloaded from the captured values.
- Outputs in GAP: sequence_out=0, bit_valid=0, busy=1.
- abort has priority over frame and gap progression. reset has priority over everything.
- A start while busy is ignored. A start in the same cycle done is high is accepted, because busy=0 in that cycle.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency:
  - Start sampled at edge N gives first bit, bit_valid and frame_start valid after edge N.
  - Bit i is valid after edge N+i.
- Single frame of length L: busy is high for L cycles. done is high for the single cycle after edge N+L. Back-to-back start is possible at that edge.
- Frame period with repeats: L+gap_in cycles. Total busy time: (repeat+1)·L + repeat·gap_in cycles.
- Abort sampled at edge M: after edge M, sequence_out, bit_valid and busy are 0, and done is not asserted.
- Asserting reset mid-frame clears all outputs immediately, without waiting for a clock edge. The first start is accepted at the first edge after reset deasserts.

## Structure
- Package seq_gen_pkg holds:
  - state enum {IDLE, SEND, GAP};
  - default MAX_LEN;
  - the 8-bit repeat width and 4-bit gap width constants.
- Sub-module seq_shift_reg: a MAX_LEN-bit parallel-load, MSB-out shift register with load, shift and length-aligned output. The top level holds the FSM and counters.
- Total RTL is about 150–250 lines.

## Test plan
- Reset and idle:
  - Stimulus: reset=1 for 3 cycles, then start=0.
  - Required: all outputs 0 throughout; busy stays 0.
- Single frame:
  - Stimulus: pattern=16'h000B, length=4, repeat=0, gap=0.
  - Required: sequence_out 1,0,1,1 on 4 consecutive cycles; frame_start on the first bit only; done one cycle later.
  - Also required: a connected sequence_detector asserts detector_out once.
- Repeats with gap:
  - Stimulus: length=3, pattern=3'b110, repeat=2, gap=2.
  - Required: bit stream 110 00 110 00 110, with bit_valid low during the gaps; 3 frame_start pulses; busy for 13 cycles; then done.
- Boundaries:
  - Stimulus: length=0, then length=20.
  - Required: for length=0, done after 1 cycle and no bits. For length=20 with MAX_LEN=16, clamped to 16 bits sent MSB-first.
- Abort and mid-operation reset:
  - Stimulus: abort at bit 2 of a 4-bit frame.
  - Required: outputs 0 on the next cycle and no done. A new start issued afterwards works normally.
  - Second case: reset asserted mid-GAP. Required: outputs cleared without waiting for a clock edge.
- Back-to-back and ignored starts:
  - Stimulus: start held high continuously.
  - Required: frames run back-to-back, re-capturing the inputs in each done cycle.
  - Stimulus: start pulsed while busy. Required: it is ignored and the captured pattern is unchanged.
